fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
  ADDR_WIDTH, 32, PC and instruction-memory address width.
  INSTR_WIDTH, 16, instruction word width.
  RESET_VECTOR, 32'h20, first fetch address after reset.
  INT_VECTOR, 32'h0, fetch address on interrupt entry.
  FIFO_DEPTH, 2, prefetch buffer entries (power of 2, at least 2).
REQ-002 The block SHALL have these ports, one per line: name  direction  width  meaning.
  clk  in  1  single clock, all state updates on posedge.
  rst  in  1  synchronous, active-low reset.
  imem_rd  out  1  instruction-memory read strobe.
  imem_addr  out  ADDR_WIDTH  read address, valid when imem_rd=1.
  imem_data  in  INSTR_WIDTH  read data, valid exactly 1 cycle after imem_rd.
  instr  out  INSTR_WIDTH  instruction at buffer head.
  instr_pc  out  ADDR_WIDTH  address of instr.
  instr_valid  out  1  head entry valid.
  instr_ready  in  1  decode accepts head.
  redirect_valid  in  1  branch/jump taken this cycle.
  redirect_pc  in  ADDR_WIDTH  branch/jump target.
  int_req  in  1  interrupt request, level, held until int_ack.
  int_ack  out  1  one-cycle interrupt-entry pulse.
  epc  out  ADDR_WIDTH  saved return address, updated on int_ack.

Function
REQ-003 fetch_pc SHALL be the internal next-fetch register; it SHALL drive imem_addr directly.
REQ-004 imem_rd SHALL be 1 iff (count + inflight) < FIFO_DEPTH and no flush occurs this cycle; inflight = 1 when imem_rd was 1 in the previous cycle and no flush occurred in that cycle.
REQ-005 On each cycle with imem_rd=1, fetch_pc SHALL increment by 1 (word addressed), modulo 2^ADDR_WIDTH; 0xFFFFFFFF SHALL wrap to 0.
REQ-006 imem_data arriving with inflight=1 SHALL be written to the FIFO tail together with its fetch address at the end of that cycle; the entry SHALL become visible on instr/instr_pc the following cycle.
REQ-007 instr_valid SHALL be 1 iff count>0 and no flush occurs this cycle; pop SHALL occur iff instr_valid and instr_ready.
REQ-008 A push and a pop in the same cycle SHALL leave count unchanged; count SHALL never exceed FIFO_DEPTH and SHALL never underflow.
REQ-009 A flush SHALL occur on a cycle with redirect_valid=1, or with int_req=1 and redirect_valid=0; redirect SHALL have priority over interrupt.
REQ-010 On flush, the block SHALL clear count to 0, discard imem_data arriving that cycle, force imem_rd=0 and instr_valid=0 (no pop), and load fetch_pc at the end of the cycle.
REQ-011 Redirect flush: fetch_pc SHALL become redirect_pc; imem_rd=1 with imem_addr=redirect_pc in cycle t+1; instr_valid with instr_pc=redirect_pc SHALL first be 1 in cycle t+3.
REQ-012 Interrupt flush: int_ack=1 for that cycle; fetch_pc SHALL become INT_VECTOR; epc SHALL load the oldest unaccepted address: the FIFO head pc if count>0, else the inflight address if inflight=1, else fetch_pc.
REQ-013 int_ack SHALL never be 1 in a cycle with redirect_valid=1; a held int_req SHALL be taken on the first cycle without redirect.
REQ-014 Back-to-back flushes SHALL each apply in full; the last flush SHALL determine fetch_pc.

Reset
REQ-015 When rst=0 at a posedge: fetch_pc=RESET_VECTOR, count=0, inflight=0, epc=0, FIFO pointers=0; during reset imem_rd=0, instr_valid=0, int_ack=0.
REQ-016 Reset SHALL override flush, push and pop in the same cycle, and reset mid-stream SHALL discard all buffered and in-flight data.
REQ-017 In the first cycle after rst returns to 1, imem_rd SHALL be 1 with imem_addr=RESET_VECTOR.

Verification
REQ-018 Release reset, instr_ready=1 -> imem_addr 0x20,0x21,0x22... each cycle; instr_valid first at cycle 2 with instr_pc=0x20, then consecutive pcs every cycle.
REQ-019 instr_ready=0 for 10 cycles -> exactly 2 entries buffered (0x20,0x21), imem_rd=0 after 2 issues; on ready=1, pcs 0x20,0x21,0x22 with no gap or duplicate.
REQ-020 redirect_valid=1, redirect_pc=0x100 while streaming -> instr_valid=0 in cycles t, t+1, t+2; instr_pc=0x100 at t+3; no pre-redirect word delivered afterwards.
REQ-021 int_req=1 with FIFO head pc 0x45 -> int_ack pulse, epc=0x45, next fetch at 0x0; int_req and redirect in the same cycle -> redirect taken, int_ack delayed one cycle.
REQ-022 redirect_pc=0xFFFFFFFF -> fetches 0xFFFFFFFF then 0x0; rst=0 asserted mid-stream -> after release, first fetch at 0x20 with empty buffer.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction prefetch unit with redirect and interrupt entry
module fetch_unit #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    INSTR_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 'h20,
  parameter logic [ADDR_WIDTH-1:0] INT_VECTOR   = 'h0,
  parameter int                    FIFO_DEPTH   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_rd,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  input  logic                   int_req,
  output logic                   int_ack,
  output logic [ADDR_WIDTH-1:0]  epc
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0]  fetch_pc;
  logic [ADDR_WIDTH-1:0]  inflight_pc;
  logic                   inflight;
  logic [CNT_W-1:0]       count;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [INSTR_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  pc_mem   [FIFO_DEPTH];

  logic                   flush;
  logic                   push;
  logic                   pop;
  logic [CNT_W:0]         occupancy;
  logic [ADDR_WIDTH-1:0]  oldest_pc;

  assign imem_addr = fetch_pc;
  assign instr     = data_mem[rd_ptr];
  assign instr_pc  = pc_mem[rd_ptr];

  // Flush detection, issue/deliver handshakes and the oldest unaccepted address for epc.
  always_comb begin
    flush       = redirect_valid | int_req;
    occupancy   = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    imem_rd     = rst & ~flush & (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    instr_valid = rst & ~flush & (count != '0);
    int_ack     = rst & int_req & ~redirect_valid;
    pop         = instr_valid & instr_ready;
    push        = rst & ~flush & inflight;
    if (count != '0) begin
      oldest_pc = pc_mem[rd_ptr];
    end else if (inflight) begin
      oldest_pc = inflight_pc;
    end else begin
      oldest_pc = fetch_pc;
    end
  end

  // Control state: fetch pointer, outstanding read, buffer occupancy and saved return address.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc    <= RESET_VECTOR;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      epc         <= '0;
    end else if (flush) begin
      // Everything buffered or in flight belongs to the abandoned path.
      fetch_pc <= redirect_valid ? redirect_pc : INT_VECTOR;
      inflight <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      if (int_ack) begin
        epc <= oldest_pc;
      end
    end else begin
      inflight <= imem_rd;
      if (imem_rd) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + ADDR_WIDTH'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      // Issue is throttled by count+inflight, so a push never finds the buffer full.
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Buffer storage: returning word and its fetch address written at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_data;
      pc_mem[wr_ptr]   <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit against a queue-based reference model
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_rd;
  logic [31:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        int_req;
  logic        int_ack;
  logic [31:0] epc;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_data(imem_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .int_req(int_req), .int_ack(int_ack), .epc(epc)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_f(input logic [31:0] a);
    return a[15:0] ^ a[31:16] ^ 16'h3C5A ^ {a[7:0], a[15:8]};
  endfunction

  // Instruction memory: one-cycle read latency, junk when no read was issued.
  always @(posedge clk) begin
    imem_data <= imem_rd ? mem_f(imem_addr) : 16'($urandom);
  end

  typedef struct packed {
    int          cyc;
    logic        rd;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic        ack;
    logic [31:0] epc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_buf[$];
  logic [31:0] m_pc = 32'h20;
  logic        m_infl = 1'b0;
  logic [31:0] m_infl_pc = 32'h0;
  logic [31:0] m_epc = 32'h0;
  int          cyc_n = 0;
  int          total = 0;
  int          bad = 0;
  logic        ir_hold = 1'b0;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
    end
  endtask

  // One cycle of stimulus; the model predicts this cycle's outputs, then advances.
  task automatic cyc(input logic r, input logic rv, input logic [31:0] rpc,
                     input logic ir, input logic rdy);
    exp_t e;
    logic fl;
    @(negedge clk);
    rst = r; redirect_valid = rv; redirect_pc = rpc; int_req = ir; instr_ready = rdy;
    fl    = rv | ir;
    e.cyc  = cyc_n;
    e.rd   = r && !fl && (m_buf.size() + int'(m_infl) < 2);
    e.addr = m_pc;
    e.vld  = r && !fl && (m_buf.size() > 0);
    e.pc   = (m_buf.size() > 0) ? m_buf[0] : 32'h0;
    e.ack  = r && ir && !rv;
    e.epc  = m_epc;
    exp_q.push_back(e);
    cyc_n++;
    if (!r) begin
      m_buf.delete(); m_infl = 1'b0; m_pc = 32'h20; m_epc = 32'h0;
    end else if (fl) begin
      if (e.ack) m_epc = (m_buf.size() > 0) ? m_buf[0] : (m_infl ? m_infl_pc : m_pc);
      m_buf.delete(); m_infl = 1'b0;
      m_pc = rv ? rpc : 32'h0;
    end else begin
      if (e.vld && rdy) void'(m_buf.pop_front());
      if (m_infl) m_buf.push_back(m_infl_pc);
      m_infl = e.rd;
      if (e.rd) begin
        m_infl_pc = m_pc;
        m_pc = m_pc + 32'd1;
      end
    end
  endtask

  // Monitor: pops the prediction for each cycle and compares once outputs have settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("imem_rd", e.cyc, 32'(imem_rd), 32'(e.rd));
        chk("imem_addr", e.cyc, imem_addr, e.addr);
        chk("instr_valid", e.cyc, 32'(instr_valid), 32'(e.vld));
        if (e.vld && instr_valid) begin
          chk("instr_pc", e.cyc, instr_pc, e.pc);
          chk("instr", e.cyc, 32'(instr), 32'(mem_f(e.pc)));
        end
        chk("int_ack", e.cyc, 32'(int_ack), 32'(e.ack));
        chk("epc", e.cyc, epc, e.epc);
      end
    end
  end

  initial begin
    logic rv;
    logic [31:0] rpc;
    logic r;
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; int_req = 1'b0; instr_ready = 1'b0;
    repeat (3) cyc(0, 0, 0, 0, 1);
    // Streaming from the reset vector.
    repeat (20) cyc(1, 0, 0, 0, 1);
    // Back-pressure: buffer fills with two entries, then drains without gap.
    repeat (10) cyc(1, 0, 0, 0, 0);
    repeat (6) cyc(1, 0, 0, 0, 1);
    // Redirect while streaming.
    cyc(1, 1, 32'h100, 0, 1);
    repeat (8) cyc(1, 0, 0, 0, 1);
    // Interrupt with head pc 0x45, then interrupt colliding with a redirect.
    cyc(1, 1, 32'h45, 0, 0);
    repeat (5) cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 1);
    repeat (6) cyc(1, 0, 0, 0, 1);
    cyc(1, 1, 32'h200, 1, 1);
    cyc(1, 0, 0, 1, 1);
    repeat (6) cyc(1, 0, 0, 0, 1);
    // Back-to-back flushes; the last one wins.
    cyc(1, 1, 32'h300, 0, 1);
    cyc(1, 1, 32'h400, 0, 1);
    repeat (5) cyc(1, 0, 0, 0, 1);
    // Address wrap at the top of the space.
    cyc(1, 1, 32'hFFFF_FFFF, 0, 1);
    repeat (6) cyc(1, 0, 0, 0, 1);
    // Reset mid-stream, with an interrupt pending during reset.
    repeat (2) cyc(0, 0, 0, 1, 1);
    repeat (6) cyc(1, 0, 0, 0, 1);
    // Randomized traffic; int_req is a level held until acknowledged.
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) != 0);
      rv = ($urandom_range(0, 99) < 5);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFD + 32'($urandom_range(0, 2))) : $urandom();
      if (!ir_hold && $urandom_range(0, 99) < 3) ir_hold = 1'b1;
      cyc(r, rv, rpc, ir_hold, $urandom_range(0, 3) != 0);
      if (r && ir_hold && !rv) ir_hold = 1'b0;
    end
    cyc(1, 0, 0, 0, 1);
    @(negedge clk);
    #2;
    chk("scoreboard_drained", cyc_n, 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
